// File: rtl/lidar_frame_packer.sv
// lidar_frame_packer
//   Packs one lidar measurement (16-bit distance + 16-bit amplitude) into an
//   8-byte frame {HDR0, HDR1, seq, dist_hi, dist_lo, amp_hi, amp_lo, csum}.
//   The frame goes out one byte at a time to a UART transmitter. Each byte is
//   paced by the transmitter's end-of-byte ready pulse. A per-byte watchdog
//   aborts the frame if that pulse never arrives.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   meas_valid/ready  measurement handshake (ready only while idle)
//   meas_dist/amp     measurement words, sampled only at acceptance
//   tx_data           byte to transmitter, held stable until acknowledged
//   tx_data_valid     one-cycle start strobe per byte
//   tx_data_ready     one-cycle pulse from transmitter after the stop bit
//   frame_busy        high while a frame is being sent
//   frame_done        one-cycle pulse, last byte acknowledged
//   frame_err         one-cycle pulse, frame aborted by the watchdog
module lidar_frame_packer #(
    parameter logic [7:0] HDR0        = 8'hAA,
    parameter logic [7:0] HDR1        = 8'h55,
    parameter int         TIMEOUT_CYC = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        meas_valid,
    input  logic [15:0] meas_dist,
    input  logic [15:0] meas_amp,
    output logic        meas_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      r_state, w_next;
    logic        r_meas_ready;
    logic [7:0]  r_tx_data;
    logic [2:0]  r_idx;
    logic [15:0] r_cnt;
    logic [7:0]  r_seq;      // sequence number for the next accepted frame
    logic [7:0]  r_seq_f;    // sequence number of the frame in flight
    logic [7:0]  r_csum;
    logic [15:0] r_dist;
    logic [15:0] r_amp;

    logic        w_accept;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  w_next_byte;
    logic [7:0]  w_csum;

    // Checksum over seq and payload; 8-bit sum drops the carries.
    assign w_csum    = r_seq + meas_dist[15:8] + meas_dist[7:0]
                             + meas_amp[15:8]  + meas_amp[7:0];
    assign w_idx_nxt = r_idx + 3'd1;

    always_comb begin
        w_next_byte = HDR0;
        case (w_idx_nxt)
            3'd1:    w_next_byte = HDR1;
            3'd2:    w_next_byte = r_seq_f;
            3'd3:    w_next_byte = r_dist[15:8];
            3'd4:    w_next_byte = r_dist[7:0];
            3'd5:    w_next_byte = r_amp[15:8];
            3'd6:    w_next_byte = r_amp[7:0];
            3'd7:    w_next_byte = r_csum;
            default: w_next_byte = HDR0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (meas_valid && r_meas_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_SEND;
                end
            end
            S_SEND:  w_next = S_WAIT;
            S_WAIT: begin
                // A ready pulse arriving in the timeout cycle still counts.
                if (tx_data_ready)
                    w_next = (r_idx == 3'd7) ? S_DONE : S_SEND;
                else if (r_cnt == TO_LAST)
                    w_next = S_ABORT;
            end
            S_DONE:  w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Datapath. tx_data is registered so it reads 0 out of reset and stays
    // put from the strobe through the whole wait for the ready pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meas_ready <= 1'b0;
            r_tx_data    <= 8'h00;
            r_idx        <= 3'd0;
            r_cnt        <= 16'd0;
            r_seq        <= 8'd0;
            r_seq_f      <= 8'd0;
            r_csum       <= 8'd0;
            r_dist       <= 16'd0;
            r_amp        <= 16'd0;
        end else begin
            r_meas_ready <= (w_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dist    <= meas_dist;
                        r_amp     <= meas_amp;
                        r_seq_f   <= r_seq;
                        r_csum    <= w_csum;
                        r_seq     <= r_seq + 8'd1;
                        r_idx     <= 3'd0;
                        r_tx_data <= HDR0;
                    end
                end
                S_SEND: r_cnt <= 16'd0;
                S_WAIT: begin
                    if (tx_data_ready) begin
                        if (r_idx != 3'd7) begin
                            r_idx     <= w_idx_nxt;
                            r_tx_data <= w_next_byte;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_ABORT: r_idx <= 3'd0;
                default: ;
            endcase
        end
    end

    assign meas_ready    = r_meas_ready;
    assign tx_data       = r_tx_data;
    assign tx_data_valid = (r_state == S_SEND);
    assign frame_busy    = (r_state == S_SEND) || (r_state == S_WAIT);
    assign frame_done    = (r_state == S_DONE);
    assign frame_err     = (r_state == S_ABORT);

endmodule

// File: tb/tb_lidar_frame_packer.sv
// Self-checking bench for lidar_frame_packer. The stimulus pushes expected
// bytes and frame outcomes into queues; a monitor pops and compares them.
module tb_lidar_frame_packer;

    localparam int TO = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        meas_valid = 1'b0;
    logic [15:0] meas_dist = 16'h0;
    logic [15:0] meas_amp = 16'h0;
    logic        tx_data_ready = 1'b0;
    logic        meas_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        frame_busy;
    logic        frame_done;
    logic        frame_err;

    lidar_frame_packer #(.HDR0(8'hAA), .HDR1(8'h55), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .meas_valid(meas_valid), .meas_dist(meas_dist), .meas_amp(meas_amp),
        .meas_ready(meas_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .frame_busy(frame_busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [7:0] exp_q[$];
    bit         end_q[$];        // 0 = frame_done expected, 1 = frame_err
    logic [7:0] seq_log[$];
    logic [7:0] csum_log[$];
    logic [7:0] last_frame[8];
    logic [7:0] tb_seq = 8'd0;   // reference sequence counter
    int         n_strobes = 0;
    int         n_end = 0;

    // Transmitter model controls
    bit tx_dead = 1'b0;
    bit race_next = 1'b0;
    bit stale_req = 1'b0;
    int tx_dmax = 6;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transmitter model: answers each strobe with a ready pulse after a delay.
    initial begin
        int d;
        forever begin
            if (rst_n && tx_data_valid && !tx_dead) begin
                d = race_next ? TO : int'($urandom_range(1, tx_dmax));
                race_next = 1'b0;
                repeat (d) @(negedge clk);
                tx_data_ready = 1'b1;
                @(negedge clk);
                tx_data_ready = 1'b0;
            end else if (stale_req) begin
                tx_data_ready = 1'b1;
                @(negedge clk);
                tx_data_ready = 1'b0;
                stale_req = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor
    initial begin
        logic [7:0] cur[8];
        logic [7:0] e;
        int  mon_idx;
        bit  prev_vld;
        bit  rdy_pend;
        bit  eb;
        int  last_cyc;
        mon_idx = 0; prev_vld = 0; rdy_pend = 0; last_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_idx = 0; prev_vld = 0; rdy_pend = 0;
            end else begin
                if (rdy_pend) begin
                    chk("ready_after_err", meas_ready, 1'b1);
                    rdy_pend = 0;
                end
                if (tx_data_valid) begin
                    if (prev_vld) chk("valid_two_cycles", 1, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", tx_data, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("byte%0d", mon_idx), tx_data, e);
                    end
                    if (mon_idx < 8) cur[mon_idx] = tx_data;
                    mon_idx++;
                    n_strobes++;
                    last_cyc = cyc;
                end
                if (frame_busy) chk("ready_low_busy", meas_ready, 1'b0);
                if (frame_done || frame_err) begin
                    if (end_q.size() == 0) begin
                        chk("unexpected_end", {frame_done, frame_err}, 2'b00);
                    end else begin
                        eb = end_q.pop_front();
                        chk("frame_outcome_err", frame_err, eb);
                        chk("frame_outcome_done", frame_done, !eb);
                    end
                    chk("bytes_left_at_end", exp_q.size(), 0);
                    if (frame_done) begin
                        seq_log.push_back(cur[2]);
                        csum_log.push_back(cur[7]);
                        for (int i = 0; i < 8; i++) last_frame[i] = cur[i];
                    end
                    if (frame_err) begin
                        chk("timeout_cycles", cyc - last_cyc, TO + 1);
                        rdy_pend = 1;
                    end
                    mon_idx = 0;
                    n_end++;
                end
                prev_vld = tx_data_valid;
            end
        end
    end

    // Reference model: build the expected frame from the current sequence.
    task automatic model_push(input logic [15:0] d, input logic [15:0] a, input bit abort);
        int s;
        s = (int'(tb_seq) + int'(d[15:8]) + int'(d[7:0]) + int'(a[15:8]) + int'(a[7:0])) % 256;
        exp_q.push_back(8'hAA);
        if (!abort) begin
            exp_q.push_back(8'h55);
            exp_q.push_back(tb_seq);
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
            exp_q.push_back(a[15:8]);
            exp_q.push_back(a[7:0]);
            exp_q.push_back(8'(s));
        end
        end_q.push_back(abort);
        tb_seq = tb_seq + 8'd1;
    endtask

    // Called at a negedge; returns at a negedge after the first strobe.
    task automatic send(input logic [15:0] d, input logic [15:0] a,
                        input bit abort, input bit hold);
        bit ok;
        ok = 0;
        meas_dist = d; meas_amp = a; meas_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (meas_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            meas_valid = 1'b0;
            return;
        end
        model_push(d, a, abort);
        @(posedge clk);
        @(negedge clk);
        chk("accept_latency", tx_data_valid, 1'b1);
        if (!hold) begin
            meas_valid = 1'b0;
            meas_dist = 16'($urandom);
            meas_amp = 16'($urandom);
        end
    endtask

    task automatic wait_ends(input int target);
        for (int i = 0; i < 20000 && n_end < target; i++) @(negedge clk);
        if (n_end < target) chk("frame_end_timeout", n_end, target);
    endtask

    task automatic check_reset_outputs();
        chk("rst_meas_ready", meas_ready, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_data_valid, 0);
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        meas_valid = 1'b0;
        #1;
        check_reset_outputs();
        repeat (12) @(negedge clk);
        check_reset_outputs();
        exp_q.delete();
        end_q.delete();
        seq_log.delete();
        csum_log.delete();
        tb_seq = 8'd0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] golden[8];
        int base;
        golden = '{8'hAA, 8'h55, 8'h00, 8'h12, 8'h34, 8'h00, 8'hFF, 8'h45};

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", meas_ready, 1);

        // Stale ready while idle must not start anything
        base = n_strobes;
        stale_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("stale_no_strobe", n_strobes, base);
        chk("stale_still_idle", meas_ready, 1);

        // Frame content
        send(16'h1234, 16'h00FF, 0, 0);
        wait_ends(n_end + 1);
        for (int i = 0; i < 8; i++) chk($sformatf("golden%0d", i), last_frame[i], golden[i]);

        // Reset mid-frame after byte index 3 is strobed
        base = n_strobes;
        send(16'hBEEF, 16'h0123, 0, 0);
        for (int i = 0; i < 500 && n_strobes < base + 4; i++) @(negedge clk);
        chk("reached_byte3", n_strobes >= base + 4, 1);
        do_reset();

        // Checksum wrap, also first frame after the reset (seq 0)
        base = n_end;
        send(16'hFFFF, 16'hFFFF, 0, 0);
        wait_ends(base + 1);
        chk("seq_after_reset", seq_log[0], 8'h00);
        chk("csum_wrap", csum_log[0], 8'hFC);

        // Timeout: dead transmitter, then next frame carries seq 1
        do_reset();
        tx_dead = 1'b1;
        base = n_end;
        send(16'h5A5A, 16'hA5A5, 1, 0);
        wait_ends(base + 1);
        tx_dead = 1'b0;
        send(16'h0001, 16'h0002, 0, 0);
        wait_ends(base + 2);
        chk("seq_after_abort", seq_log[0], 8'h01);

        // Ready on the exact timeout cycle counts as sent
        race_next = 1'b1;
        base = n_end;
        send(16'h7777, 16'h8888, 0, 0);
        wait_ends(base + 1);

        // Random frames
        for (int k = 0; k < 20; k++) begin
            tx_dmax = int'($urandom_range(1, 6));
            base = n_end;
            send(16'($urandom), 16'($urandom), 0, 0);
            wait_ends(base + 1);
        end

        // Sequence wrap: 257 back-to-back zero frames
        do_reset();
        tx_dmax = 2;
        base = n_end;
        for (int k = 0; k < 257; k++) send(16'h0, 16'h0, 0, (k < 256));
        meas_valid = 1'b0;
        wait_ends(base + 257);
        chk("wrap_frames", seq_log.size(), 257);
        if (seq_log.size() == 257) begin
            chk("wrap_seq255", seq_log[255], 8'hFF);
            chk("wrap_csum255", csum_log[255], 8'hFF);
            chk("wrap_seq256", seq_log[256], 8'h00);
            chk("wrap_csum256", csum_log[256], 8'h00);
        end

        repeat (5) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "time limit");
    end

endmodule
